// File: rtl/copro_vec_sequencer.sv
// copro_vec_sequencer: multi-cycle execution stage for the example CV-X-IF
// vector coprocessor. Takes one predecoded custom vector instruction, walks
// the internal vector register one element per cycle, then returns a single
// result transaction to the core.
// Optional feature: define CVXIF_VEC_KILL_EN to honour kill_i in EXEC/RESP.

package copro_vec_pkg;
    typedef enum logic [1:0] {
        MV_V_X   = 2'd0,
        ADD_V_X  = 2'd1,
        REDSUM_V = 2'd2
    } custom_vec_op_e;
endpackage

module copro_vec_sequencer
    import copro_vec_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned VLMAX     = 8,
    parameter int unsigned VlenWidth = 4,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  custom_vec_op_e       op_i,
    input  logic [VlenWidth-1:0] vlen_i,
    input  logic [XLEN-1:0]      rs1_i,
    input  logic [IdWidth-1:0]   id_i,
    input  logic [4:0]           rd_i,
    input  logic                 wb_i,
    input  logic                 kill_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [IdWidth-1:0]   result_id_o,
    output logic [XLEN-1:0]      result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o
);

    localparam int unsigned IdxW = $clog2(VLMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    custom_vec_op_e       op_q;
    logic [XLEN-1:0]      rs1_q;
    logic [IdWidth-1:0]   id_q;
    logic [4:0]           rd_q;
    logic                 wb_q;
    logic [VlenWidth-1:0] len_q;
    logic [VlenWidth-1:0] cnt_q;
    logic [XLEN-1:0]      acc_q;
    logic [XLEN-1:0]      v_q [VLMAX];

    logic [VlenWidth-1:0] eff_len;
    logic [IdxW-1:0]      elem_idx;
    logic [IdxW-1:0]      last_idx;
    logic                 last_elem;
    logic                 kill;

`ifdef CVXIF_VEC_KILL_EN
    assign kill = kill_i;
`else
    logic unused_kill;
    assign unused_kill = kill_i;
    assign kill        = 1'b0;
`endif

    // Clamp the requested length to the register size; never wraps.
    assign eff_len   = (vlen_i > VlenWidth'(VLMAX)) ? VlenWidth'(VLMAX) : vlen_i;
    assign elem_idx  = IdxW'(cnt_q);
    assign last_idx  = IdxW'(len_q - VlenWidth'(1));
    assign last_elem = (cnt_q == len_q - VlenWidth'(1));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and result interface outputs.
    always_comb begin
        state_d        = state_q;
        issue_ready_o  = 1'b0;
        result_valid_o = 1'b0;
        result_id_o    = '0;
        result_data_o  = '0;
        result_rd_o    = '0;
        result_we_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i) begin
                    state_d = (eff_len == '0) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (last_elem) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                result_valid_o = 1'b1;
                result_id_o    = id_q;
                result_rd_o    = rd_q;
                result_we_o    = wb_q;
                if (len_q == '0) begin
                    result_data_o = '0;
                end else if (op_q == REDSUM_V) begin
                    result_data_o = acc_q;
                end else begin
                    result_data_o = v_q[last_idx];
                end
                if (kill || result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction latch and per-element datapath; vector contents persist
    // across instructions and are cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q  <= MV_V_X;
            rs1_q <= '0;
            id_q  <= '0;
            rd_q  <= '0;
            wb_q  <= 1'b0;
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            for (int unsigned i = 0; i < VLMAX; i++) begin
                v_q[i] <= '0;
            end
        end else if (state_q == IDLE && issue_valid_i) begin
            op_q  <= op_i;
            rs1_q <= rs1_i;
            id_q  <= id_i;
            rd_q  <= rd_i;
            wb_q  <= wb_i;
            len_q <= eff_len;
            cnt_q <= '0;
            acc_q <= '0;
        end else if (state_q == EXEC && !kill) begin
            // Unrecognised op encodings fall through to the move behaviour.
            case (op_q)
                ADD_V_X:  v_q[elem_idx] <= v_q[elem_idx] + rs1_q;
                REDSUM_V: acc_q <= acc_q + v_q[elem_idx];
                default:  v_q[elem_idx] <= rs1_q;
            endcase
            cnt_q <= cnt_q + VlenWidth'(1);
        end
    end

endmodule

// File: doc/copro_vec_sequencer.md
# copro_vec_sequencer

Multi-cycle execution stage of the example CV-X-IF coprocessor, directly downstream of the instruction predecoder. It takes one accepted custom vector instruction, with its decoded operation, vector length, scalar operand and writeback info. It then walks the elements of an internal vector register one per cycle and returns a single result-interface transaction to the core.

## Interface
- XLEN, 32: element and scalar operand width.
- VLMAX, 8: number of elements in the internal vector register (power of two, 2..64).
- VlenWidth, 4: width of the vlen input; must hold VLMAX.
- IdWidth, 4: width of the instruction ID.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  predecoder-accepted instruction available.
- issue_ready_o  out  1  sequencer can take an instruction.
- op_i  in  custom_vec_op_e  decoded op: MV_V_X, ADD_V_X, REDSUM_V.
- vlen_i  in  VlenWidth  requested element count.
- rs1_i  in  XLEN  scalar operand.
- id_i  in  IdWidth  instruction ID.
- rd_i  in  5  destination register.
- wb_i  in  1  instruction writes back to the integer register file.
- kill_i  in  1  abort in-flight instruction (only with CVXIF_VEC_KILL_EN).
- result_valid_o  out  1  result transaction valid.
- result_ready_i  in  1  core takes the result.
- result_id_o  out  IdWidth  ID of the completing instruction.
- result_data_o  out  XLEN  result value.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  register-file write enable (= latched wb_i).

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE, all vector elements 0, accumulator 0, element counter 0, all outputs 0 except issue_ready_o.
- IDLE: issue_ready_o = 1.
  - On issue_valid_i, latch op, rs1, id, rd and wb. Latch effective length L = min(vlen_i, VLMAX). Clear counter and accumulator.
  - Go to EXEC if L > 0, else go to RESP.
- EXEC: issue_ready_o = 0. At counter value i, process element i:
  - MV_V_X: v[i] ← rs1.
  - ADD_V_X: v[i] ← v[i] + rs1, modulo 2^XLEN.
  - REDSUM_V: acc ← acc + v[i], modulo 2^XLEN; v unchanged.
  - Counter increments. When i = L−1, go to RESP.
- RESP: result_valid_o = 1 with id, rd and we stable.
  - result_data_o = acc for REDSUM_V; v[L−1] for MV/ADD; 0 when L = 0.
  - Hold all result outputs until result_ready_i, then go to IDLE. No new issue is accepted in the same cycle.
- Vector register contents persist across instructions. Only reset clears them.
- vlen_i > VLMAX is clamped; never wraps.
- Any op value other than the three above is processed as MV_V_X.

## Timing
- Issue handshake at edge T. EXEC occupies T+1 .. T+L. result_valid_o rises at T+L+1.
- L = 0: result_valid_o at T+1.
- Throughput: at most one instruction per L+2 cycles, given immediate result_ready_i.
- result_ready_i high in the RESP entry cycle completes the transaction in that cycle. issue_ready_o is high the following cycle.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values, with no result emitted and no partial flag.

## Configuration
- CVXIF_VEC_KILL_EN defined: kill_i sampled in EXEC and RESP.
  - Kill in EXEC: FSM returns to IDLE next cycle; elements already written stay written; no result.
  - Kill in RESP: result_valid_o drops next cycle without handshake.
  - Kill in IDLE is ignored.
- Undefined: kill_i port still present but ignored; every accepted instruction produces exactly one result.

## Test plan
- Reset, then MV_V_X with vlen=4, rs1=0x5 -> v[0..3]=5; result_valid at T+5 with data 0x5; issue_ready low during T+1..T+5.
- Following ADD_V_X with vlen=4, rs1=0xFFFFFFFF -> v[0..3]=4 (wrap); result data 0x4. Then REDSUM_V with vlen=4 -> data 0x10.
- vlen=0 with REDSUM_V, id=3 -> result_valid at T+1, data 0, id 3; vector register unchanged.
- vlen=15 with VLMAX=8, MV_V_X rs1=7 -> exactly 8 EXEC cycles, data 7.
- result_ready_i held low for 5 cycles in RESP -> all result outputs stable; issue_valid_i ignored until the handshake.
- With CVXIF_VEC_KILL_EN: kill_i at EXEC element 2 of MV_V_X with vlen=6 -> no result; v[0..1] updated, v[2..5] unchanged; issue_ready high next cycle. Reset mid-EXEC -> all elements 0.
